uart_receiver: RTL
==================

Name: uart_receiver

Overview:
- Serial-to-parallel receive stage of the link. Samples the asynchronous serial line and reassembles 8-bit frames.
- Presents each byte to the nibble decoder that sits immediately downstream, on data_out with a one-cycle valid strobe.
- Frame format: 1 start bit (low), 8 data bits LSB-first, 1 even-parity bit (when the optional feature is compiled in), 1 stop bit (high).
- Line is high when idle. Uses 16x oversampling derived from the system clock.

Parameters:
- BAUD_DIV, 326: system clocks per oversample tick (50 MHz / (9600*16), rounded). Legal range 2..65535.
- OVERSAMPLE, 16: oversample ticks per bit. Fixed, not for override.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- rx_en  in  1  receiver enable; low holds the block in IDLE
- rx_in  in  1  asynchronous serial line, idle high
- data_out  out  8  last correctly received byte; held until the next good frame
- rx_valid  out  1  one-clk pulse when data_out is updated
- rx_perror  out  1  parity mismatch on last frame; sticky until the next start bit is accepted
- rx_ferror  out  1  stop bit sampled low on last frame; sticky until the next start bit is accepted
- rx_busy  out  1  high from start-bit acceptance to end of the stop bit

Behaviour:
- Reset: asynchronous and active-high. All outputs go to 0, state goes to IDLE, and the tick counter and sample counter clear. Reset mid-frame aborts the frame; no strobe is produced.
- Input sync: rx_in passes through a 2-flop synchroniser, preset to 1 on reset. All decisions use the synchronised value, so latency adds 2 clks.
- Tick generator: counts 0..BAUD_DIV-1 and pulses tick for one clk at BAUD_DIV-1. It free-runs while rx_en=1 and is held at 0 while rx_en=0.
- FSM states: IDLE, START, DATA, PARITY, STOP. All state transitions happen only on tick, except the rx_en abort.
- IDLE:
  - On tick with synchronised rx=0, go to START and clear the sample counter.
- START:
  - On the 8th tick (mid-bit), re-check the line.
  - Line still 0: accept the start bit. Set rx_busy=1, clear rx_perror and rx_ferror, go to DATA with bit index 0.
  - Line 1: false start. Return to IDLE; no flags change.
- DATA: every 16th tick after the mid-start sample, shift the line into bit[idx], LSB first. After idx 7, go to PARITY (feature compiled in) or STOP.
- PARITY: 16 ticks later, sample the line. Mismatch against the even parity of the 8 data bits (XOR of data bits differs from sampled bit) sets perr_int. Go to STOP.
- STOP: 16 ticks later, sample the line.
  - Line 0 sets rx_ferror=1.
  - rx_perror is loaded from perr_int.
  - If both errors are 0: load data_out and pulse rx_valid for exactly one clk.
  - rx_busy goes to 0 and the FSM returns to IDLE on that same tick. IDLE then requires a new falling level, so a back-to-back frame is supported.
- Errored frame: data_out keeps its previous value; rx_valid does not pulse.
- rx_en deasserted mid-frame: next clk returns to IDLE, rx_busy=0, no strobe. data_out and the flags are unchanged.
- Line held low (break): the frame ends with rx_ferror=1. The FSM stays in IDLE and re-enters START only when the line goes high and then falls again; a low-held line must not retrigger.
- Latency: the rx_valid pulse occurs 2 clks (sync) + 1 clk after the stop-bit mid-sample tick.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: the PARITY state exists (11-bit frame) and rx_perror is driven as described above.
- Undefined: 10-bit frame; STOP follows DATA directly; rx_perror is tied to 0.

Decomposition:
- Package uart_pkg holds:
  - FSM state encoding (localparams, 3-bit).
  - OVERSAMPLE=16, MID_SAMPLE=8, DATA_BITS=8.
  - Default BAUD_DIV.
- The same package is shared with the transmitter.
- One sub-module: uart_baud_tick. Inputs clk, reset, en; output tick; parameter BAUD_DIV. The transmitter reuses it.

Test Plan (BAUD_DIV=4 in simulation; bit period = 64 clks; parity compiled in unless stated):
- Reset pulse mid-frame during DATA -> all outputs 0 immediately; the next clean frame 0x5B is received correctly with rx_valid pulsing once.
- Frame 0x5B, even parity bit 1, stop 1 -> data_out=0x5B, rx_valid high for exactly 1 clk, both flags 0.
- Frame 0xA3 with parity bit forced to 1 (correct value 0) -> rx_perror=1, rx_valid never pulses, data_out retains 0x5B.
- Frame 0x12 with stop bit 0 -> rx_ferror=1, no strobe. The next frame 0x34 clears both flags at start acceptance and delivers 0x34.
- Glitch: line low for 3 ticks only -> FSM returns to IDLE, no rx_busy, no strobe.
- UART_RX_PARITY_EN undefined: back-to-back frames 0x00 then 0xFF with no idle gap -> two strobes exactly 640 clks apart, rx_perror constantly 0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, FSM state encoding and helpers
package uart_pkg;

    // Oversampling geometry (fixed by the link definition)
    localparam int OVERSAMPLE       = 16;
    localparam int MID_SAMPLE       = 8;
    localparam int DATA_BITS        = 8;

    // 50 MHz / (9600 * 16), rounded
    localparam int DEFAULT_BAUD_DIV = 326;

    // FSM state encoding, shared by receiver and transmitter
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } uart_state_t;

    // Even parity bit for a data byte: the bit that makes the total count of ones even
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator, one-clk pulse every BAUD_DIV clocks
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    // 16-bit counter covers the full 2..65535 divider range
    localparam logic [15:0] CNT_LAST = 16'(BAUD_DIV - 1);

    logic [15:0] cnt;

    // Free-running divider while enabled; parked at zero when disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 16'd0;
        end else if (!en || cnt == CNT_LAST) begin
            cnt <= 16'd0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    assign tick = en && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 16x oversampled UART receiver; optional even parity via UART_RX_PARITY_EN
module uart_receiver
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_en,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       rx_perror,
    output logic       rx_ferror,
    output logic       rx_busy
);

    localparam logic [3:0] SAMPLE_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_LAST    = 4'(MID_SAMPLE - 1);
    localparam logic [2:0] IDX_LAST    = 3'(DATA_BITS - 1);

    logic [1:0]           sync;
    logic                 rx_s;
    logic                 tick;
    uart_state_t          state;
    logic [3:0]           sample_cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
    // Set once the line has been seen high in IDLE; a start needs a fresh falling level
    logic                 armed;
`ifdef UART_RX_PARITY_EN
    logic                 perr_int;
`endif

    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (rx_en),
        .tick  (tick)
    );

    // Two-flop synchroniser, preset to the idle (high) line level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx_in};
        end
    end

    assign rx_s = sync[1];

`ifndef UART_RX_PARITY_EN
    assign rx_perror = 1'b0;
`endif

    // Frame FSM: all decisions on oversample ticks, outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sample_cnt <= 4'd0;
            bit_idx    <= 3'd0;
            shift      <= '0;
            armed      <= 1'b0;
            data_out   <= 8'd0;
            rx_valid   <= 1'b0;
            rx_ferror  <= 1'b0;
            rx_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_int   <= 1'b0;
            rx_perror  <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            if (!rx_en) begin
                // Abort: drop the frame, keep data_out and flags
                state      <= IDLE;
                sample_cnt <= 4'd0;
                rx_busy    <= 1'b0;
                armed      <= 1'b0;
            end else begin
                if (state == IDLE && rx_s) begin
                    armed <= 1'b1;
                end
                if (tick) begin
                    case (state)
                        IDLE: begin
                            if (!rx_s && armed) begin
                                state      <= START;
                                sample_cnt <= 4'd0;
                                armed      <= 1'b0;
                            end
                        end
                        START: begin
                            if (sample_cnt == MID_LAST) begin
                                sample_cnt <= 4'd0;
                                if (!rx_s) begin
                                    // Genuine start bit: new frame, clear last frame's flags
                                    rx_busy   <= 1'b1;
                                    rx_ferror <= 1'b0;
`ifdef UART_RX_PARITY_EN
                                    rx_perror <= 1'b0;
                                    perr_int  <= 1'b0;
`endif
                                    bit_idx   <= 3'd0;
                                    state     <= DATA;
                                end else begin
                                    state <= IDLE;
                                end
                            end else begin
                                sample_cnt <= sample_cnt + 4'd1;
                            end
                        end
                        DATA: begin
                            if (sample_cnt == SAMPLE_LAST) begin
                                sample_cnt <= 4'd0;
                                shift      <= {rx_s, shift[DATA_BITS-1:1]};
                                bit_idx    <= bit_idx + 3'd1;
                                if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                                    state <= PARITY;
`else
                                    state <= STOP;
`endif
                                end
                            end else begin
                                sample_cnt <= sample_cnt + 4'd1;
                            end
                        end
`ifdef UART_RX_PARITY_EN
                        PARITY: begin
                            if (sample_cnt == SAMPLE_LAST) begin
                                sample_cnt <= 4'd0;
                                perr_int   <= rx_s ^ even_parity(shift);
                                state      <= STOP;
                            end else begin
                                sample_cnt <= sample_cnt + 4'd1;
                            end
                        end
`endif
                        STOP: begin
                            if (sample_cnt == SAMPLE_LAST) begin
                                sample_cnt <= 4'd0;
                                rx_ferror  <= !rx_s;
`ifdef UART_RX_PARITY_EN
                                rx_perror  <= perr_int;
                                if (rx_s && !perr_int) begin
`else
                                if (rx_s) begin
`endif
                                    data_out <= shift;
                                    rx_valid <= 1'b1;
                                end
                                rx_busy <= 1'b0;
                                // A low stop (break) leaves us disarmed until the line rises
                                armed   <= rx_s;
                                state   <= IDLE;
                            end else begin
                                sample_cnt <= sample_cnt + 4'd1;
                            end
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule
